// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv run controller and its halt detector.
package riscv_pkg;

    localparam int XLEN = 32;

    // Instructions that end a run on sight.
    localparam logic [XLEN-1:0] INSTR_ECALL    = 32'h0000_0073;
    localparam logic [XLEN-1:0] INSTR_JAL_SELF = 32'h0000_006F;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CORE_RST,
        RUN,
        DUMP,
        DONE
    } run_state_e;

    // True for an instruction that is itself a halt marker.
    function automatic logic is_halt_instr(input logic [XLEN-1:0] instr);
        return (instr == INSTR_ECALL) || (instr == INSTR_JAL_SELF);
    endfunction

endpackage

// File: rtl/riscv_halt_detect.sv
// Halt detector: flags ecall, jal-to-self, or a PC that has stopped moving.
// The halt output is combinational so the controller can leave RUN on the same edge.
module riscv_halt_detect
    import riscv_pkg::*;
#(
    parameter int HALT_REPEAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run_en,
    input  logic [XLEN-1:0] core_pc,
    input  logic [XLEN-1:0] core_instr,
    output logic            halt
);

    localparam int RCW = $clog2(HALT_REPEAT + 1);
    localparam logic [RCW-1:0] REPEAT_LIMIT = RCW'(HALT_REPEAT);

    logic [XLEN-1:0] prev_pc;
    logic            prev_valid;
    logic [RCW-1:0]  repeat_cnt;
    logic [RCW-1:0]  repeat_next;
    logic            pc_same;

    // Count consecutive cycles the PC has not moved and raise halt on a marker or a stall.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        pc_same     = prev_valid && (core_pc == prev_pc);
        repeat_next = '0;
        if (pc_same) begin
            repeat_next = (repeat_cnt == REPEAT_LIMIT) ? repeat_cnt : repeat_cnt + 1'b1;
        end
        halt = run_en && (is_halt_instr(core_instr) || (repeat_next == REPEAT_LIMIT));
    end

    // Track the previous PC only while running; the first RUN cycle has nothing to compare against.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset || !run_en) begin
            prev_valid <= 1'b0;
            prev_pc    <= '0;
            repeat_cnt <= '0;
        end else begin
            prev_valid <= 1'b1;
            prev_pc    <= core_pc;
            repeat_cnt <= repeat_next;
        end
    end

endmodule

// File: rtl/riscv_run_controller.sv
// Run controller: streams a program into instruction memory, sequences core reset,
// runs the core until halt or budget exhaustion, then streams out the register file.
module riscv_run_controller
    import riscv_pkg::*;
#(
    parameter int IMEM_DEPTH      = 256,
    parameter int NUM_REGS        = 32,
    parameter int MAX_CYCLES      = 1000,
    parameter int CORE_RST_CYCLES = 2,
    parameter int HALT_REPEAT     = 2,
    localparam int IMEM_AW = $clog2(IMEM_DEPTH),
    localparam int RAW     = $clog2(NUM_REGS),
    localparam int CW      = $clog2(MAX_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [IMEM_AW-1:0] load_addr,
    input  logic [XLEN-1:0]    load_data,
    input  logic               load_last,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [XLEN-1:0]    imem_wdata,
    output logic               core_reset,
    output logic               core_hold,
    input  logic [XLEN-1:0]    core_pc,
    input  logic [XLEN-1:0]    core_instr,
    output logic [RAW-1:0]     reg_rd_addr,
    input  logic [XLEN-1:0]    reg_rd_data,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [RAW-1:0]     dump_idx,
    output logic [XLEN-1:0]    dump_data,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CW-1:0]      cycle_count
);

    localparam int RSTW = $clog2(CORE_RST_CYCLES + 1);
    localparam logic [CW-1:0]   CYCLE_LIMIT = CW'(MAX_CYCLES);
    localparam logic [RAW-1:0]  LAST_IDX    = RAW'(NUM_REGS - 1);
    localparam logic [RSTW-1:0] RST_LAST    = RSTW'(CORE_RST_CYCLES - 1);

    run_state_e      state;
    logic [RSTW-1:0] rst_cnt;
    logic [CW-1:0]   cycle_next;
    logic            run_en;
    logic            halt;

    assign run_en     = (state == RUN);
    assign cycle_next = (cycle_count == CYCLE_LIMIT) ? cycle_count : cycle_count + 1'b1;

    // The register file is read asynchronously, so the dump data follows the index directly.
    assign reg_rd_addr = dump_idx;
    assign dump_data   = reg_rd_data;

    riscv_halt_detect #(
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_detect (
        .clk        (clk),
        .reset      (reset),
        .run_en     (run_en),
        .core_pc    (core_pc),
        .core_instr (core_instr),
        .halt       (halt)
    );

    // Run sequencer: state and all registered outputs advance together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            core_reset  <= 1'b1;
            core_hold   <= 1'b1;
            load_ready  <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            dump_valid  <= 1'b0;
            dump_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            // The write strobe is a single-cycle pulse; only an accepted beat raises it.
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= LOAD;
                        load_ready  <= 1'b1;
                        core_reset  <= 1'b1;
                        core_hold   <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                    end
                end
                LOAD: begin
                    if (load_valid && load_ready) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= load_addr;
                        imem_wdata <= load_data;
                        if (load_last) begin
                            state      <= CORE_RST;
                            load_ready <= 1'b0;
                            rst_cnt    <= '0;
                        end
                    end
                end
                CORE_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                        core_hold  <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    cycle_count <= cycle_next;
                    // A halt in the same cycle as budget exhaustion is a clean halt.
                    if (halt || (cycle_next == CYCLE_LIMIT)) begin
                        state      <= DUMP;
                        core_hold  <= 1'b1;
                        timeout    <= !halt;
                        dump_valid <= 1'b1;
                        dump_idx   <= '0;
                    end
                end
                DUMP: begin
                    if (dump_ready) begin
                        if (dump_idx == LAST_IDX) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            dump_idx <= dump_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
